sfu_seq: RTL and testbench

SFU_SEQ -- requirements
Module: sfu_seq

---
 rtl/sfu_seq_pkg.sv | 21 ++
 rtl/sfu_seq.sv | 122 ++++++++++++
 tb/tb_sfu_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sfu_seq_pkg.sv
// Shared SFU definitions: op encodings used by both the sequencer and the SFU, plus sequencer states.
// The RELU state exists only when SFU_SEQ_RELU_EN is defined.
package sfu_seq_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_RELU = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIRST = 3'd1,
        ST_ACCUM = 3'd2,
`ifdef SFU_SEQ_RELU_EN
        ST_RELU  = 3'd3,
`endif
        ST_WAIT  = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

endpackage

// File: rtl/sfu_seq.sv
// Sequencer that feeds num_acc psums into the SFU as SET/ACC(/RELU) commands and returns the result.
// Optional RELU post-step compiled in with SFU_SEQ_RELU_EN.
//
// Handshakes: a transfer happens at a rising edge where valid & ready are both 1; valid never
// waits on ready, and out_valid/out_data hold stable until the transfer.
module sfu_seq
    import sfu_seq_pkg::*;
#(
    parameter int PSUM_BW = 16,
    parameter int CNT_BW  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNT_BW-1:0]         num_acc,
    input  logic                      relu_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [PSUM_BW-1:0] in_psum,
    output logic [1:0]                op,
    output logic signed [PSUM_BW-1:0] op_psum,
    input  logic signed [PSUM_BW-1:0] sfu_acc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [PSUM_BW-1:0] out_data,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                dbg_state
);

    state_t            state;
    state_t            post_last;
    logic [CNT_BW-1:0] count;
    logic [CNT_BW-1:0] num_lat;
    logic              relu_lat;
    logic [CNT_BW:0]   count_inc;
    logic              last_psum;
    logic              handshake;

    // One extra bit so num_acc = 2^CNT_BW-1 compares without wrapping.
    assign count_inc = {1'b0, count} + 1'b1;
    assign last_psum = count_inc >= {1'b0, num_lat};

    assign in_ready  = ~reset & ((state == ST_FIRST) | (state == ST_ACCUM));
    assign handshake = in_valid & in_ready;
    assign busy      = ~reset & (state != ST_IDLE);
    assign dbg_state = state;

`ifdef SFU_SEQ_RELU_EN
    assign post_last = relu_lat ? ST_RELU : ST_WAIT;
`else
    logic unused_relu;
    assign unused_relu = relu_lat;
    assign post_last   = ST_WAIT;
`endif

    always_comb begin
        op      = OP_NOP;
        op_psum = '0;
        if (handshake) begin
            op      = (state == ST_FIRST) ? OP_SET : OP_ACC;
            op_psum = in_psum;
        end
`ifdef SFU_SEQ_RELU_EN
        if (~reset && state == ST_RELU) begin
            op = OP_RELU;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            num_lat   <= '0;
            relu_lat  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_acc == '0) begin
                            done <= 1'b1;
                        end else begin
                            num_lat  <= num_acc;
                            relu_lat <= relu_en;
                            count    <= '0;
                            state    <= ST_FIRST;
                        end
                    end
                end
                ST_FIRST, ST_ACCUM: begin
                    if (handshake) begin
                        count <= count_inc[CNT_BW-1:0];
                        state <= last_psum ? post_last : ST_ACCUM;
                    end
                end
`ifdef SFU_SEQ_RELU_EN
                ST_RELU: state <= ST_WAIT;
`endif
                // The SFU has absorbed its last command by now; capture its accumulator.
                ST_WAIT: begin
                    out_data  <= sfu_acc;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfu_seq.sv
// Bench for sfu_seq driving a behavioural SFU; expected results come from summing each job's psum list.
module tb_sfu_seq;
    import sfu_seq_pkg::*;

`ifdef SFU_SEQ_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         num_acc = '0;
    logic               relu_en = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_psum = '0;
    logic [1:0]         op;
    logic signed [15:0] op_psum;
    logic signed [15:0] sfu_acc;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic               busy;
    logic               done;
    logic [2:0]         dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] job_ps[$];
    logic [15:0]        exp_q[$];
    logic [1:0]         exp_op_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    sfu_seq #(.PSUM_BW(16), .CNT_BW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .num_acc(num_acc), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .op(op), .op_psum(op_psum), .sfu_acc(sfu_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // Behavioural SFU
    always @(posedge clk) begin
        if (reset) sfu_acc <= '0;
        else begin
            case (op)
                OP_SET:  sfu_acc <= op_psum;
                OP_ACC:  sfu_acc <= sfu_acc + op_psum;
                OP_RELU: if (sfu_acc < 0) sfu_acc <= '0;
                default: ;
            endcase
        end
    end

    // ---------------- driver: one job from job_ps ----------------
    task automatic run_job(input int n, input bit relu, input int gap, input int rdy_delay, input bit poke_start);
        logic signed [15:0] acc;
        logic [15:0]        exp_res;
        logic [1:0]         eop;
        int                 lat;
        acc = '0;
        foreach (job_ps[i]) acc = acc + job_ps[i];
        if (RELU_ON && relu && acc < 0) acc = '0;
        exp_q.push_back(acc);
        for (int i = 0; i < n; i++) exp_op_q.push_back(i == 0 ? OP_SET : OP_ACC);
        if (RELU_ON && relu) exp_op_q.push_back(OP_RELU);
        lat = (RELU_ON && relu) ? 2 : 1;

        @(negedge clk);
        start = 1'b1; num_acc = 8'(n); relu_en = relu; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_idle_busy: got %0b want 0", busy); end
        @(negedge clk);
        start = 1'b0; num_acc = 8'($urandom); relu_en = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0; in_psum = 16'($urandom);
                #1;
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL gap_in_ready: got %0b want 1", in_ready); end
                n_checks++; if (op !== OP_NOP) begin n_fail++; $display("FAIL gap_op: got %0d want %0d", op, OP_NOP); end
                n_checks++; if (op_psum !== 16'sd0) begin n_fail++; $display("FAIL gap_op_psum: got %0d want 0", op_psum); end
                @(negedge clk);
            end
            in_valid = 1'b1; in_psum = job_ps[i];
            #1;
            eop = exp_op_q.pop_front();
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL feed_in_ready: psum %0d got %0b want 1", i, in_ready); end
            n_checks++; if (op !== eop) begin n_fail++; $display("FAIL feed_op: psum %0d got %0d want %0d", i, op, eop); end
            n_checks++; if (op_psum !== job_ps[i]) begin n_fail++; $display("FAIL feed_op_psum: psum %0d got %0d want %0d", i, op_psum, job_ps[i]); end
            @(negedge clk);
        end
        in_valid = 1'b0; in_psum = 16'($urandom);
        for (int k = 0; k < lat; k++) begin
            #1;
            eop = (k == 0 && lat == 2) ? exp_op_q.pop_front() : OP_NOP;
            n_checks++; if (op !== eop) begin n_fail++; $display("FAIL post_op: cycle %0d got %0d want %0d", k, op, eop); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL early_out_valid: cycle %0d got %0b want 0", k, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL post_in_ready: cycle %0d got %0b want 0", k, in_ready); end
            @(negedge clk);
        end
        exp_res = exp_q.pop_front();
        for (int d = 0; d <= rdy_delay; d++) begin
            out_ready = (d == rdy_delay);
            start = poke_start && (d == 1);
            num_acc = 8'd1;
            #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL out_valid: hold %0d got %0b want 1", d, out_valid); end
            n_checks++; if (out_data !== exp_res) begin n_fail++; $display("FAIL out_data: hold %0d got %0d want %0d", d, out_data, $signed(exp_res)); end
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL early_done: hold %0d got %0b want 0", d, done); end
            @(negedge clk);
        end
        out_ready = 1'b0; start = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %0b want 1", done); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_valid_drop: got %0b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL end_busy: got %0b want 0", busy); end
        @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_single: got %0b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_job: got %0b want 0", busy); end
        n_checks++; if (exp_op_q.size() != 0) begin n_fail++; $display("FAIL op_seq_len: got %0d left want 0", exp_op_q.size()); end
        exp_op_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; in_psum = 16'sd7; num_acc = 8'd3;
        repeat (3) begin
            @(negedge clk); #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
            n_checks++; if (op !== OP_NOP) begin n_fail++; $display("FAIL rst_op: got %0d want 0", op); end
            n_checks++; if (op_psum !== 16'sd0) begin n_fail++; $display("FAIL rst_op_psum: got %0d want 0", op_psum); end
            n_checks++; if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got v%0b d%0b b%0b want 000", out_valid, done, busy); end
            n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        end
        start = 1'b0; in_valid = 1'b0; reset = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got b%0b r%0b want 00", busy, in_ready); end
    endtask

    task automatic test_basic();
        job_ps = '{16'sd5, -16'sd2, 16'sd7};
        run_job(3, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_relu();
        job_ps = '{-16'sd4, 16'sd1};
        run_job(2, 1'b1, 0, 0, 1'b0);
    endtask

    task automatic test_gaps();
        job_ps = '{16'sd1, 16'sd1, 16'sd1};
        run_job(3, 1'b0, 2, 0, 1'b0);
    endtask

    task automatic test_out_stall();
        job_ps = '{16'($urandom_range(0, 500)), 16'($urandom_range(0, 500))};
        run_job(2, 1'b0, 0, 4, 1'b1);
    endtask

    task automatic test_zero();
        @(negedge clk);
        start = 1'b1; num_acc = 8'd0; relu_en = 1'b0; in_valid = 1'b1; in_psum = 16'sd3;
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_early: got %0b want 0", done); end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0b want 1", done); end
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got b%0b r%0b want 00", busy, in_ready); end
        n_checks++; if (op !== OP_NOP || op_psum !== 16'sd0) begin n_fail++; $display("FAIL zero_op: got %0d/%0d want 0/0", op, op_psum); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_after: got d%0b b%0b want 00", done, busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; num_acc = 8'd3; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_psum = 16'sd4;
        #1;
        n_checks++; if (op !== OP_SET) begin n_fail++; $display("FAIL mid_first_op: got %0d want %0d", op, OP_SET); end
        @(negedge clk);
        in_psum = 16'sd6; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0 || op !== OP_NOP || op_psum !== 16'sd0) begin n_fail++; $display("FAIL mid_rst_in: got r%0b op%0d p%0d want 0/0/0", in_ready, op, op_psum); end
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'sd0) begin n_fail++; $display("FAIL mid_rst_out: got v%0b d%0d want 0/0", out_valid, out_data); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got b%0b d%0b want 00", busy, done); end
        in_valid = 1'b0;
        job_ps = '{16'sd9};
        run_job(1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_max();
        job_ps.delete();
        for (int i = 0; i < 255; i++) job_ps.push_back(16'($urandom_range(0, 200)) - 16'sd100);
        run_job(255, 1'b1, 0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 20; j++) begin
            int n;
            n = $urandom_range(1, 8);
            job_ps.delete();
            for (int i = 0; i < n; i++) job_ps.push_back(16'($urandom));
            run_job(n, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_gaps();
        test_out_stall();
        test_zero();
        test_reset_mid();
        test_max();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
